// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared definitions for the multi-cycle RV32I sequencer: state encodings,
//   the state enum built on them, and the default memory-wait timeout.
//   No ports (package).
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

   // Legacy 3-bit state encodings, kept so external debug taps keep decoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd6;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      FETCH  = ST_FETCH,
      DECODE = ST_DECODE,
      EXEC   = ST_EXEC,
      MEM    = ST_MEM,
      WB     = ST_WB,
      FAULT  = ST_FAULT
   } state_e;

   localparam int unsigned DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Instruction/data memory handshake bundle between the sequencer and the
//   memory ports.
//   imem_req   : instruction fetch request (sequencer -> memory)
//   imem_ready : fetch data valid this cycle (memory -> sequencer)
//   dmem_req   : data access request (sequencer -> memory)
//   dmem_we    : 1 = store, 0 = load, valid while dmem_req
//   dmem_ready : data access complete this cycle (memory -> sequencer)
//   master = sequencer side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ready;

   modport master (
      output imem_req,
      output dmem_req,
      output dmem_we,
      input  imem_ready,
      input  dmem_ready
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  dmem_we,
      output imem_ready,
      output dmem_ready
   );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_wait_timer
//   Counts consecutive not-ready cycles of a memory handshake. Shared between
//   the fetch and data-access phases; the owner clears it on phase entry.
//   clk       : core clock
//   rst       : asynchronous active-high reset
//   i_clear   : zero the counter (priority over i_count)
//   i_count   : a request cycle without ready; advance the counter
//   o_expired : this is the last allowed not-ready cycle; never set when
//               TIMEOUT = 0
// -----------------------------------------------------------------------------
module multicycle_ctrl_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_count && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds the number of earlier not-ready cycles, so when it reaches
   // TIMEOUT-1 the current cycle is the TIMEOUT-th one.
   assign o_expired = (TIMEOUT != 0) && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer for the single-issue RV32I core. Steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB, drives the memory
//   handshakes, IR/PC/RF write enables and a retired-instruction counter.
//   clk            : core clock
//   rst            : asynchronous active-high reset
//   start          : run enable, sampled in IDLE and at retire
//   mem            : memory handshake bundle (master side)
//   ir_we          : latch instruction register
//   dec_reg_write  : decoder, instruction writes rd
//   dec_mem_read   : decoder, load
//   dec_mem_write  : decoder, store
//   dec_branch     : decoder, conditional branch
//   branch_taken   : datapath, branch condition true
//   rf_we          : register-file write enable
//   pc_we          : PC update (retire pulse)
//   pc_src         : 0 = pc+4, 1 = branch target, valid with pc_we
//   busy           : sequencer not idle
//   fault          : sticky timeout / illegal-control flag
//   instret        : retired-instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
   parameter int unsigned PERF_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   multicycle_ctrl_if.master mem,
   output logic              ir_we,
   input  logic              dec_reg_write,
   input  logic              dec_mem_read,
   input  logic              dec_mem_write,
   input  logic              dec_branch,
   input  logic              branch_taken,
   output logic              rf_we,
   output logic              pc_we,
   output logic              pc_src,
   output logic              busy,
   output logic              fault,
   output logic [PERF_W-1:0] instret
);

   state_e              r_state;
   state_e              w_next;
   logic                r_fault;
   logic [PERF_W-1:0]   r_instret;
   logic                w_retire;
   logic                w_wait;
   logic                w_expired;
   logic                w_clear;

   // Any state change clears the timer; FETCH and MEM are only ever entered
   // through a change, so each wait phase starts from zero.
   assign w_clear = (w_next != r_state);

   multicycle_ctrl_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_count   (w_wait),
      .o_expired (w_expired)
   );

   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      w_wait   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = FETCH;
         end
         FETCH: begin
            if (mem.imem_ready) begin
               w_next = DECODE;
            end else begin
               w_wait = 1'b1;
               if (w_expired) w_next = FAULT;
            end
         end
         DECODE: w_next = EXEC;
         EXEC: begin
            if (dec_mem_read && dec_mem_write)      w_next = FAULT;
            else if (dec_mem_read || dec_mem_write) w_next = MEM;
            else if (dec_reg_write)                 w_next = WB;
            else                                    w_retire = 1'b1;
         end
         MEM: begin
            if (mem.dmem_ready) begin
               if (dec_mem_write) w_retire = 1'b1;
               else               w_next   = WB;
            end else begin
               w_wait = 1'b1;
               if (w_expired) w_next = FAULT;
            end
         end
         WB:      w_retire = 1'b1;
         FAULT:   w_next   = FAULT;
         default: w_next   = FAULT;
      endcase
      if (w_retire) w_next = start ? FETCH : IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_fault   <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == FAULT) r_fault <= 1'b1;
         if (w_retire) r_instret <= r_instret + PERF_W'(1);
      end
   end

   // Requests and pulses decode straight from state so reset drops them at once.
   assign mem.imem_req = (r_state == FETCH);
   assign mem.dmem_req = (r_state == MEM);
   assign mem.dmem_we  = (r_state == MEM) && dec_mem_write;
   assign ir_we        = (r_state == FETCH) && mem.imem_ready;
   assign rf_we        = (r_state == WB);
   assign pc_we        = w_retire;
   assign pc_src       = w_retire && dec_branch && branch_taken;
   assign busy         = (r_state != IDLE);
   assign fault        = r_fault;
   assign instret      = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ir_we, rf_we, pc_we, pc_src, busy, fault;
   logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, branch_taken;
   logic [31:0] instret;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(
      .TIMEOUT (TO),
      .PERF_W  (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mem           (bus),
      .ir_we         (ir_we),
      .dec_reg_write (dec_reg_write),
      .dec_mem_read  (dec_mem_read),
      .dec_mem_write (dec_mem_write),
      .dec_branch    (dec_branch),
      .branch_taken  (branch_taken),
      .rf_we         (rf_we),
      .pc_we         (pc_we),
      .pc_src        (pc_src),
      .busy          (busy),
      .fault         (fault),
      .instret       (instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pc_src;
      int unsigned rf_pulses;
      int unsigned lat;
      int unsigned dreq;
      logic [31:0] instret;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [31:0] m_instret;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dec(input logic rw, input logic mr, input logic mw,
                          input logic br, input logic tk);
      dec_reg_write = rw;
      dec_mem_read  = mr;
      dec_mem_write = mw;
      dec_branch    = br;
      branch_taken  = tk;
   endtask

   // Called with the DUT in its FETCH entry cycle, 1 time unit after the edge.
   task automatic run_instr(input string nm, input logic rw, input logic mr, input logic mw,
                            input logic br, input logic tk, input int unsigned iw,
                            input int unsigned dw, input bit drop);
      exp_t        e;
      exp_t        g;
      bit          memop, wb, done;
      int unsigned fw, dwc, irc, rfc;
      memop = mr | mw;
      wb    = mr | (!memop & rw);
      set_dec(rw, mr, mw, br, tk);
      e.pc_src    = br & tk;
      e.rf_pulses = wb ? 1 : 0;
      e.dreq      = memop ? dw + 1 : 0;
      e.lat       = iw + 3 + (memop ? dw + 1 : 0) + (wb ? 1 : 0);
      e.instret   = m_instret + 1;
      exp_q.push_back(e);
      chk({nm, "/fetch_entry"}, {31'b0, bus.imem_req}, 1);
      fw = 0; dwc = 0; irc = 0; rfc = 0; done = 0;
      for (int unsigned c = 1; c <= 64 && !done; c++) begin
         bus.imem_ready = bus.imem_req && (fw == iw);
         bus.dmem_ready = bus.dmem_req && (dwc == dw);
         #1;
         if (bus.imem_req) fw++;
         if (bus.dmem_req) begin
            dwc++;
            chk({nm, "/dmem_we"}, {31'b0, bus.dmem_we}, {31'b0, mw});
            if (drop) start = 1'b0;
         end
         if (ir_we) irc++;
         if (rf_we) rfc++;
         if (pc_we) begin
            g = exp_q.pop_front();
            chk({nm, "/latency"}, c, g.lat);
            chk({nm, "/pc_src"}, {31'b0, pc_src}, {31'b0, g.pc_src});
            chk({nm, "/rf_we_pulses"}, rfc, g.rf_pulses);
            chk({nm, "/dmem_req_cycles"}, dwc, g.dreq);
            chk({nm, "/ir_we_pulses"}, irc, 1);
            done = 1;
         end
         @(posedge clk);
         #1;
         bus.imem_ready = 1'b0;
         bus.dmem_ready = 1'b0;
      end
      if (!done) begin
         chk({nm, "/retire_seen"}, 0, 1);
         void'(exp_q.pop_front());
      end
      m_instret = e.instret;
      chk({nm, "/instret"}, instret, e.instret);
      chk({nm, "/next_fetch"}, {31'b0, bus.imem_req}, {31'b0, start});
      chk({nm, "/busy_after"}, {31'b0, busy}, {31'b0, start});
   endtask

   initial begin
      int unsigned reqc;
      rst = 1'b1;
      start = 1'b0;
      set_dec(0, 0, 0, 0, 0);
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      m_instret = '0;
      repeat (3) next_cyc();
      chk("reset/busy", {31'b0, busy}, 0);
      chk("reset/fault", {31'b0, fault}, 0);
      chk("reset/instret", instret, 0);
      chk("reset/outs", {25'b0, bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, rf_we, pc_we, pc_src}, 0);

      rst = 1'b0;
      start = 1'b1;
      next_cyc();
      //         name        rw mr mw br tk iw  dw drop
      run_instr("add",       1, 0, 0, 0, 0, 0,  0, 0);
      run_instr("lw",        1, 1, 0, 0, 0, 0,  3, 0);
      run_instr("beq_taken", 0, 0, 0, 1, 1, 0,  0, 0);
      run_instr("bne_not",   0, 0, 0, 1, 0, 2,  0, 0);
      run_instr("addi_iw15", 1, 0, 0, 0, 0, 15, 0, 0);
      run_instr("sw_dw15",   0, 0, 1, 0, 0, 0,  15, 0);
      run_instr("sw_drop",   0, 0, 1, 0, 0, 1,  2, 1);
      next_cyc();
      chk("idle_hold/busy", {31'b0, busy}, 0);
      start = 1'b1;
      next_cyc();
      run_instr("nop",       0, 0, 0, 0, 0, 0,  0, 0);

      // Reset in the middle of a load's data access.
      set_dec(1, 1, 0, 0, 0);
      bus.imem_ready = 1'b1;
      next_cyc();
      bus.imem_ready = 1'b0;
      next_cyc();
      next_cyc();
      chk("rst_mem/dmem_req_before", {31'b0, bus.dmem_req}, 1);
      rst = 1'b1;
      #1;
      chk("rst_mem/dmem_req_now", {31'b0, bus.dmem_req}, 0);
      start = 1'b0;
      m_instret = '0;
      next_cyc();
      rst = 1'b0;
      next_cyc();
      chk("rst_mem/busy", {31'b0, busy}, 0);
      chk("rst_mem/instret", instret, m_instret);

      // Illegal load+store combination.
      start = 1'b1;
      next_cyc();
      set_dec(0, 1, 1, 0, 0);
      bus.imem_ready = 1'b1;
      next_cyc();
      bus.imem_ready = 1'b0;
      next_cyc();
      chk("illegal/pc_we_exec", {31'b0, pc_we}, 0);
      next_cyc();
      chk("illegal/fault", {31'b0, fault}, 1);
      chk("illegal/dmem_req", {31'b0, bus.dmem_req}, 0);
      chk("illegal/instret", instret, m_instret);
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      set_dec(0, 0, 0, 0, 0);
      chk("illegal/fault_cleared", {31'b0, fault}, 0);

      // Fetch that never completes.
      start = 1'b1;
      next_cyc();
      reqc = 0;
      for (int unsigned c = 0; c < 40 && !fault; c++) begin
         #1;
         if (bus.imem_req) reqc++;
         next_cyc();
      end
      chk("timeout/req_cycles", reqc, TO);
      chk("timeout/fault", {31'b0, fault}, 1);
      bus.imem_ready = 1'b1;
      bus.dmem_ready = 1'b1;
      for (int unsigned c = 0; c < 4; c++) begin
         next_cyc();
         chk("timeout/outs_zero",
             {25'b0, bus.imem_req, bus.dmem_req, bus.dmem_we, ir_we, rf_we, pc_we, pc_src}, 0);
         chk("timeout/sticky", {31'b0, fault}, 1);
      end
      rst = 1'b1;
      next_cyc();
      rst = 1'b0;
      start = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      next_cyc();
      chk("timeout/rst_clears", {30'b0, fault, busy}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
